// File: rtl/clock_monitor.sv
// clock_monitor: times half periods of a slow asynchronous square wave in the iclk
// domain, and reports per-edge measurements, frequency lock, faults and stuck input.
module clock_monitor #(
  parameter int CNT_W         = 32,
  parameter int EXPECTED_HALF = 6250000,
  parameter int TOLERANCE     = 625,
  parameter int LOCK_COUNT    = 4
) (
  input  logic             iclk,
  input  logic             irst_n,
  input  logic             isig,
  output logic             oedge_rise,
  output logic             oedge_fall,
  output logic             ovalid,
  output logic [CNT_W-1:0] ohalf_count,
  output logic             olocked,
  output logic             ofault,
  output logic             ostuck
);

  // state   | meaning
  // IDLE    | no reference edge since reset or timeout
  // MEASURE | timing half periods, counting consecutive good ones
  // LOCKED  | LOCK_COUNT good halves seen; any bad half drops lock
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MEASURE = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [CNT_W:0]    ext_t;
  typedef logic [GOOD_W-1:0] good_t;

  localparam ext_t LO_LIM  = (EXPECTED_HALF > TOLERANCE) ? ext_t'(EXPECTED_HALF - TOLERANCE) : '0;
  localparam ext_t HI_LIM  = ext_t'(EXPECTED_HALF + TOLERANCE);
  localparam cnt_t CNT_MAX = '1;

  logic       sync1_q, sync2_q, prev_q;
  cnt_t       cnt_q, cnt_d;
  good_t      good_cnt_q, good_cnt_d, good_inc;
  logic [1:0] state_q, state_d;
  logic       edge_rise_q, edge_rise_d;
  logic       edge_fall_q, edge_fall_d;
  logic       valid_q, valid_d;
  cnt_t       half_q, half_d;
  logic       locked_q, locked_d;
  logic       fault_q, fault_d;
  logic       stuck_q, stuck_d;

  logic edge_det, m_good, timeout;
  ext_t m_ext;
  cnt_t m_sat;

  always_comb begin
    edge_det = (sync2_q != prev_q);
    m_ext    = ext_t'(cnt_q) + ext_t'(1);
    m_sat    = m_ext[CNT_W] ? CNT_MAX : m_ext[CNT_W-1:0];
    m_good   = (m_ext >= LO_LIM) && (m_ext <= HI_LIM);
    timeout  = !edge_det && (ext_t'(cnt_q) == HI_LIM);
    good_inc = good_cnt_q + good_t'(1);

    if (edge_det)             cnt_d = '0;
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                      cnt_d = cnt_q + cnt_t'(1);

    edge_rise_d = edge_det && sync2_q;
    edge_fall_d = edge_det && !sync2_q;
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    valid_d     = 1'b0;
    fault_d     = 1'b0;
    half_d      = half_q;
    locked_d    = locked_q;
    stuck_d     = stuck_q;

    case (state_q)
      IDLE: begin
        // the interval ending at this edge has no start reference, so it is not reported
        if (edge_det) begin
          state_d    = MEASURE;
          stuck_d    = 1'b0;
          good_cnt_d = '0;
        end else if (timeout) begin
          stuck_d = 1'b1;
        end
      end
      MEASURE: begin
        if (edge_det) begin
          valid_d = 1'b1;
          half_d  = m_sat;
          if (m_good) begin
            good_cnt_d = good_inc;
            if (good_inc == good_t'(LOCK_COUNT)) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            good_cnt_d = '0;
          end
        end else if (timeout) begin
          state_d    = IDLE;
          stuck_d    = 1'b1;
          locked_d   = 1'b0;
          good_cnt_d = '0;
        end
      end
      LOCKED: begin
        if (edge_det) begin
          valid_d = 1'b1;
          half_d  = m_sat;
          if (!m_good) begin
            state_d    = MEASURE;
            fault_d    = 1'b1;
            locked_d   = 1'b0;
            good_cnt_d = '0;
          end
        end else if (timeout) begin
          state_d    = IDLE;
          stuck_d    = 1'b1;
          locked_d   = 1'b0;
          good_cnt_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        locked_d   = 1'b0;
        good_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      prev_q      <= 1'b0;
      cnt_q       <= '0;
      good_cnt_q  <= '0;
      state_q     <= IDLE;
      edge_rise_q <= 1'b0;
      edge_fall_q <= 1'b0;
      valid_q     <= 1'b0;
      half_q      <= '0;
      locked_q    <= 1'b0;
      fault_q     <= 1'b0;
      stuck_q     <= 1'b0;
    end else begin
      sync1_q     <= isig;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      cnt_q       <= cnt_d;
      good_cnt_q  <= good_cnt_d;
      state_q     <= state_d;
      edge_rise_q <= edge_rise_d;
      edge_fall_q <= edge_fall_d;
      valid_q     <= valid_d;
      half_q      <= half_d;
      locked_q    <= locked_d;
      fault_q     <= fault_d;
      stuck_q     <= stuck_d;
    end
  end

  assign oedge_rise  = edge_rise_q;
  assign oedge_fall  = edge_fall_q;
  assign ovalid      = valid_q;
  assign ohalf_count = half_q;
  assign olocked     = locked_q;
  assign ofault      = fault_q;
  assign ostuck      = stuck_q;

endmodule

// File: tb/tb_clock_monitor.sv
// tb_clock_monitor: drives edge schedules built from half-period lists and compares
// every output each cycle against a timestamp-based model of the monitor's rules.
module tb_clock_monitor;

  localparam int CNT_W = 8;
  localparam int EH    = 8;
  localparam int TOL   = 1;
  localparam int LOCKN = 4;
  localparam int MAXC  = 4000;

  logic             iclk   = 1'b0;
  logic             irst_n = 1'b0;
  logic             isig   = 1'b0;
  logic             oedge_rise, oedge_fall, ovalid, olocked, ofault, ostuck;
  logic [CNT_W-1:0] ohalf_count;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;
  int ncyc   = 0;
  int gaps[$];

  bit         is_edge[MAXC];
  bit         e_rise[MAXC], e_fall[MAXC], e_valid[MAXC], e_lock[MAXC], e_fault[MAXC], e_stuck[MAXC];
  logic [7:0] e_half[MAXC];

  always #5 iclk = ~iclk;

  clock_monitor #(
    .CNT_W(CNT_W), .EXPECTED_HALF(EH), .TOLERANCE(TOL), .LOCK_COUNT(LOCKN)
  ) dut (
    .iclk(iclk), .irst_n(irst_n), .isig(isig),
    .oedge_rise(oedge_rise), .oedge_fall(oedge_fall), .ovalid(ovalid),
    .ohalf_count(ohalf_count), .olocked(olocked), .ofault(ofault), .ostuck(ostuck)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rise"},   32'(oedge_rise),  0);
    check({tag, "_fall"},   32'(oedge_fall),  0);
    check({tag, "_valid"},  32'(ovalid),      0);
    check({tag, "_half"},   32'(ohalf_count), 0);
    check({tag, "_locked"}, 32'(olocked),     0);
    check({tag, "_fault"},  32'(ofault),      0);
    check({tag, "_stuck"},  32'(ostuck),      0);
  endtask

  // Edge c is the cycle whose posedge shows the edge pulse; the model works on edge
  // timestamps: a measurement is the distance between consecutive edges, and a
  // timeout fires EH+TOL+1 cycles after the last edge (reset counts as an edge at -1).
  task automatic build(input int first, input int tail);
    int  t, last, run, half, gap;
    bit  idle_m, lk, st, lvl, good;
    foreach (is_edge[i]) is_edge[i] = 1'b0;
    t = first;
    is_edge[t] = 1'b1;
    foreach (gaps[i]) begin
      t += gaps[i];
      is_edge[t] = 1'b1;
    end
    ncyc = t + tail;
    last = -1; run = 0; half = 0; idle_m = 1'b1; lk = 1'b0; st = 1'b0; lvl = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      e_rise[c] = 1'b0; e_fall[c] = 1'b0; e_valid[c] = 1'b0; e_fault[c] = 1'b0;
      if (is_edge[c]) begin
        gap = c - last;
        lvl = !lvl;
        e_rise[c] = lvl;
        e_fall[c] = !lvl;
        if (idle_m) begin
          idle_m = 1'b0; st = 1'b0; run = 0;
        end else begin
          e_valid[c] = 1'b1;
          half = gap;
          good = (gap >= EH - TOL) && (gap <= EH + TOL);
          if (lk) begin
            if (!good) begin e_fault[c] = 1'b1; lk = 1'b0; run = 0; end
          end else if (good) begin
            run++;
            if (run == LOCKN) lk = 1'b1;
          end else begin
            run = 0;
          end
        end
        last = c;
      end else if (c - last == EH + TOL + 1) begin
        st = 1'b1; lk = 1'b0; idle_m = 1'b1; run = 0;
      end
      e_lock[c]  = lk;
      e_stuck[c] = st;
      e_half[c]  = 8'(half);
    end
  endtask

  task automatic run_sched();
    for (int c = 0; c < ncyc; c++) begin
      @(posedge iclk);
      #1;
      cyc = c;
      check("rise",   32'(oedge_rise),  32'(e_rise[c]));
      check("fall",   32'(oedge_fall),  32'(e_fall[c]));
      check("valid",  32'(ovalid),      32'(e_valid[c]));
      check("half",   32'(ohalf_count), 32'(e_half[c]));
      check("locked", 32'(olocked),     32'(e_lock[c]));
      check("fault",  32'(ofault),      32'(e_fault[c]));
      check("stuck",  32'(ostuck),      32'(e_stuck[c]));
      if (c + 3 < MAXC && is_edge[c+3]) isig = ~isig;
    end
  endtask

  task automatic reset_phase();
    @(negedge iclk);
    irst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      isig = 1'($urandom_range(0, 1));
      @(posedge iclk);
      #1;
      cyc = i;
      check_zero("in_reset");
    end
    isig = 1'b0;
    @(negedge iclk);
    irst_n = 1'b1;
  endtask

  initial begin
    // main run: lock, fault/relock, never-lock, tolerance limits, random, stuck
    gaps.delete();
    repeat (8) gaps.push_back(8);
    gaps.push_back(6);
    repeat (5) gaps.push_back(8);
    repeat (5) gaps.push_back(10);
    repeat (3) begin gaps.push_back(7); gaps.push_back(9); end
    repeat (30) gaps.push_back(int'($urandom_range(5, 12)));
    repeat (5) gaps.push_back(int'($urandom_range(7, 9)));
    gaps.push_back(15);
    repeat (6) gaps.push_back(int'($urandom_range(7, 9)));
    gaps.push_back(10);
    repeat (4) gaps.push_back(8);
    build(4, 25);
    reset_phase();
    run_sched();

    // lock, then abort with an asynchronous reset mid half period
    gaps.delete();
    repeat (6) gaps.push_back(8);
    build(4, 5);
    reset_phase();
    run_sched();
    #2;
    irst_n = 1'b0;
    #1;
    check_zero("async_rst");
    isig = 1'b0;
    repeat (2) @(negedge iclk);

    // after reset: threshold-cycle edge is a bad measurement, then lock, stuck, relock
    gaps.delete();
    gaps.push_back(10);
    repeat (4) gaps.push_back(8);
    gaps.push_back(11);
    repeat (5) gaps.push_back(8);
    build(4, 25);
    irst_n = 1'b1;
    run_sched();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
